// File: rtl/uart_rx_param_if.sv
// Host-side bundle of the parametrised UART receiver: received word,
// valid/ready handshake and one-clock error/status flags.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dataOut;
  logic                 dataValid;
  logic                 dataReady;
  logic                 frameErr;
  logic                 parityErr;
  logic                 overrunErr;
  logic                 busy;

  modport master (
    output dataOut, dataValid, frameErr, parityErr, overrunErr, busy,
    input  dataReady
  );

  modport slave (
    input  dataOut, dataValid, frameErr, parityErr, overrunErr, busy,
    output dataReady
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: configurable width, optional parity,
// 1 or 2 stop bits; delivers words over valid/ready and flags framing/parity/overrun.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sampleTick,
  input  logic rxIn,
  uart_rx_param_if.master host
);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic           ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 sync_meta;
  logic                 rx_sync;
  logic [TCW-1:0]       tick_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 stop_bad_now;

  // Folds the current stop sample in so the final stop bit decides on the same edge.
  assign stop_bad_now = stop_bad | ~rx_sync;
  assign host.busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b1;
      rx_sync   <= 1'b1;
    end else begin
      sync_meta <= rxIn;
      rx_sync   <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      par_bad         <= 1'b0;
      stop_bad        <= 1'b0;
      host.dataOut    <= '0;
      host.dataValid  <= 1'b0;
      host.frameErr   <= 1'b0;
      host.parityErr  <= 1'b0;
      host.overrunErr <= 1'b0;
    end else begin
      host.frameErr   <= 1'b0;
      host.parityErr  <= 1'b0;
      host.overrunErr <= 1'b0;
      if (host.dataValid && host.dataReady) host.dataValid <= 1'b0;

      if (sampleTick) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              par_bad  <= 1'b0;
              stop_bad <= 1'b0;
              state    <= rx_sync ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                // bit_cnt is reused as the stop-bit counter from here on.
                bit_cnt <= '0;
                state   <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              par_bad  <= (rx_sync != ((^shift_reg) ^ ODD));
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (bit_cnt == STOP_LAST) begin
                bit_cnt <= '0;
                state   <= IDLE;
                if (stop_bad_now) begin
                  host.frameErr <= 1'b1;
                end else if (par_bad) begin
                  host.parityErr <= 1'b1;
                end else if (host.dataValid && !host.dataReady) begin
                  host.overrunErr <= 1'b1;
                end else begin
                  host.dataOut   <= shift_reg;
                  host.dataValid <= 1'b1;
                end
              end else begin
                stop_bad <= stop_bad_now;
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations (8N1, 8E1, 9N2) driven
// with directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_param;
  typedef enum int {EV_GOOD, EV_FRAME, EV_PARITY, EV_OVERRUN} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [8:0] data;
  } ev_t;

  logic       clk  = 1'b0;
  logic       tick = 1'b1;
  logic       rst;
  logic       rst_c;
  logic       tick_mode;
  logic [2:0] rx;
  logic [2:0] rdy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fall_cyc;

  ev_t        exp_q[3][$];
  bit         pending[3];
  logic [8:0] last_word[3];
  int         last_load_cyc[3];
  bit         prev_v[3];
  bit         prev_acc[3];

  int nbits_of[3]   = '{8, 8, 9};
  int par_en_of[3]  = '{0, 1, 0};
  int par_odd_of[3] = '{0, 0, 0};
  int nstop_of[3]   = '{1, 1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) tick = tick_mode ? 1'b1 : ($urandom_range(0, 3) != 0);

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(9)) if_c ();
  assign if_a.dataReady = rdy[0];
  assign if_b.dataReady = rdy[1];
  assign if_c.dataReady = rdy[2];

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .sampleTick(tick), .rxIn(rx[0]), .host(if_a));
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut_b (.clk(clk), .rst(rst), .sampleTick(tick), .rxIn(rx[1]), .host(if_b));
  uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut_c (.clk(clk), .rst(rst_c), .sampleTick(tick), .rxIn(rx[2]), .host(if_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor side: every observed output event must match the head of the queue.
  task automatic take(input int d, input ev_kind_t kind, input logic [8:0] data);
    ev_t e;
    if (exp_q[d].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d: got %s data 0x%0h, expected no event",
               d, kind.name(), data);
    end else begin
      e = exp_q[d].pop_front();
      check($sformatf("event_kind dut%0d", d), kind, e.kind);
      if (e.kind == EV_GOOD && kind == EV_GOOD)
        check($sformatf("event_data dut%0d", d), data, e.data);
    end
  endtask

  task automatic observe(input int d, input logic v, input logic r, input logic [8:0] dout,
                         input logic fe, input logic pe, input logic oe);
    logic load;
    load = v && (!prev_v[d] || prev_acc[d]);
    prev_v[d]   = v;
    prev_acc[d] = v && r;
    if (load === 1'b1) begin
      last_load_cyc[d] = cyc;
      take(d, EV_GOOD, dout);
    end
    if (fe === 1'b1) take(d, EV_FRAME, '0);
    if (pe === 1'b1) take(d, EV_PARITY, '0);
    if (oe === 1'b1) take(d, EV_OVERRUN, '0);
  endtask

  always @(negedge clk) begin
    observe(0, if_a.dataValid, if_a.dataReady, {1'b0, if_a.dataOut},
            if_a.frameErr, if_a.parityErr, if_a.overrunErr);
    observe(1, if_b.dataValid, if_b.dataReady, {1'b0, if_b.dataOut},
            if_b.frameErr, if_b.parityErr, if_b.overrunErr);
    observe(2, if_c.dataValid, if_c.dataReady, if_c.dataOut,
            if_c.frameErr, if_c.parityErr, if_c.overrunErr);
  end

  task automatic check_outputs(input int d, input string tag, input logic ev,
                               input logic [8:0] ed, input logic eb);
    logic v, b;
    logic [8:0] o;
    logic [2:0] e;
    case (d)
      0: begin v = if_a.dataValid; o = {1'b0, if_a.dataOut}; b = if_a.busy;
               e = {if_a.frameErr, if_a.parityErr, if_a.overrunErr}; end
      1: begin v = if_b.dataValid; o = {1'b0, if_b.dataOut}; b = if_b.busy;
               e = {if_b.frameErr, if_b.parityErr, if_b.overrunErr}; end
      default: begin v = if_c.dataValid; o = if_c.dataOut; b = if_c.busy;
               e = {if_c.frameErr, if_c.parityErr, if_c.overrunErr}; end
    endcase
    check({tag, "_valid"}, v, ev);
    check({tag, "_data"}, o, ed);
    check({tag, "_busy"}, b, eb);
    check({tag, "_errs"}, e, 3'b000);
  endtask

  function automatic logic get_busy(input int d);
    case (d)
      0: return if_a.busy;
      1: return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  // Frame-level reference: stop bits first, then parity, then the handshake state.
  function automatic ev_t predict(input int d, input logic [8:0] data,
                                  input logic par_bit, input logic [1:0] stops);
    ev_t  e;
    logic stop_ok;
    logic exp_par;
    e.data  = data & 9'((1 << nbits_of[d]) - 1);
    exp_par = (^e.data) ^ (par_odd_of[d] != 0);
    stop_ok = stops[0] && (nstop_of[d] < 2 || stops[1]);
    if (!stop_ok) e.kind = EV_FRAME;
    else if (par_en_of[d] != 0 && par_bit != exp_par) e.kind = EV_PARITY;
    else if (pending[d] && !rdy[d]) e.kind = EV_OVERRUN;
    else e.kind = EV_GOOD;
    return e;
  endfunction

  task automatic wait_ticks(input int n);
    int i = 0;
    while (i < n) begin
      @(posedge clk);
      if (tick) i++;
    end
  endtask

  task automatic send_frame(input int d, input logic [8:0] data,
                            input logic par_bit, input logic [1:0] stops);
    @(posedge clk);
    #1 rx[d] = 1'b0;
    fall_cyc = cyc;
    wait_ticks(16);
    for (int i = 0; i < nbits_of[d]; i++) begin
      #1 rx[d] = data[i];
      wait_ticks(16);
    end
    if (par_en_of[d] != 0) begin
      #1 rx[d] = par_bit;
      wait_ticks(16);
    end
    for (int s = 0; s < nstop_of[d]; s++) begin
      #1 rx[d] = stops[s];
      wait_ticks(16);
    end
    #1 rx[d] = 1'b1;
  endtask

  task automatic issue(input int d, input logic [8:0] data,
                       input logic par_bit, input logic [1:0] stops);
    ev_t e;
    e = predict(d, data, par_bit, stops);
    exp_q[d].push_back(e);
    if (e.kind == EV_GOOD) begin
      pending[d]   = !rdy[d];
      last_word[d] = e.data;
    end
    send_frame(d, data, par_bit, stops);
  endtask

  task automatic wait_drain(input int d);
    int i = 0;
    while (exp_q[d].size() != 0 && i < 4000) begin
      @(posedge clk);
      i++;
    end
    if (exp_q[d].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: %0d events outstanding, expected 0", d, exp_q[d].size());
      exp_q[d].delete();
    end
    wait_ticks(40);
    #1 check($sformatf("idle_busy dut%0d", d), get_busy(d), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat;
    logic [8:0] w;
    logic pb;
    logic [1:0] st;

    rst = 1'b1; rst_c = 1'b1; rx = '1; rdy = '1; tick_mode = 1'b1;
    for (int d = 0; d < 3; d++) begin pending[d] = 0; last_word[d] = '0; end
    repeat (3) @(posedge clk);
    #1 for (int d = 0; d < 3; d++) check_outputs(d, $sformatf("in_reset%0d", d), 1'b0, 9'h0, 1'b0);
    rst = 1'b0; rst_c = 1'b0;
    repeat (2) @(posedge clk);
    #1 for (int d = 0; d < 3; d++) check_outputs(d, $sformatf("after_reset%0d", d), 1'b0, 9'h0, 1'b0);

    // 0x55 on 8N1 with a tick every clock: latency from the falling edge.
    issue(0, 9'h055, 1'b0, 2'b11);
    wait_drain(0);
    lat = last_load_cyc[0] - fall_cyc;
    checks++;
    if (lat < 153 || lat > 155) begin
      errors++;
      $display("FAIL latency: got %0d clks, expected 153..155", lat);
    end

    // Four-clock low glitch while idle is rejected at the start-bit sample.
    @(posedge clk);
    #1 rx[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx[0] = 1'b1;
    check("glitch_busy_high", if_a.busy, 1'b1);
    repeat (20) @(posedge clk);
    #1 check_outputs(0, "glitch_done", 1'b0, last_word[0], 1'b0);

    issue(0, 9'h0A3, 1'b0, 2'b00);
    wait_drain(0);
    check_outputs(0, "frame_keep", 1'b0, last_word[0], 1'b0);

    issue(1, 9'h007, 1'b0, 2'b11);
    wait_drain(1);
    issue(1, 9'h007, 1'b1, 2'b11);
    wait_drain(1);

    // Back-to-back frames with the consumer stalled.
    rdy[0] = 1'b0;
    issue(0, 9'h012, 1'b0, 2'b11);
    issue(0, 9'h034, 1'b0, 2'b11);
    wait_drain(0);
    check_outputs(0, "overrun_hold", 1'b1, 9'h012, 1'b0);
    @(posedge clk);
    #1 rdy[0] = 1'b1;
    pending[0] = 0;
    @(posedge clk);
    #1 check("ready_clears_valid", if_a.dataValid, 1'b0);

    // 9N2: second stop bit low, then a good word left pending, then reset mid-frame.
    rdy[2] = 1'b0;
    issue(2, 9'h1FF, 1'b0, 2'b01);
    wait_drain(2);
    issue(2, 9'h1FF, 1'b0, 2'b11);
    wait_drain(2);
    check_outputs(2, "c_pending", 1'b1, 9'h1FF, 1'b0);
    @(posedge clk);
    #1 rx[2] = 1'b0;
    repeat (60) @(posedge clk);
    #1 check("c_midframe_busy", if_c.busy, 1'b1);
    #2 rst_c = 1'b1;
    #1 check_outputs(2, "c_async_reset", 1'b0, 9'h0, 1'b0);
    rx[2] = 1'b1;
    pending[2] = 0;
    last_word[2] = '0;
    repeat (3) @(posedge clk);
    #1 rst_c = 1'b0;
    rdy[2] = 1'b1;
    issue(2, 9'h0A5, 1'b0, 2'b11);
    wait_drain(2);

    // Random frames on all three receivers with an irregular sample tick.
    tick_mode = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int d = 0; d < 3; d++) begin
        w  = 9'($urandom);
        pb = (^(w & 9'((1 << nbits_of[d]) - 1))) ^ ($urandom_range(0, 3) == 0);
        st = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
        issue(d, w, pb, st);
        wait_drain(d);
      end
    end

    for (int d = 0; d < 3; d++) check($sformatf("final_queue dut%0d", d), exp_q[d].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
